// File: rtl/mac_accum_pkg.sv
// Shared types and helpers for the saturating accumulator and its adder.
package mac_accum_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Largest value an unsigned w-bit register can hold, widened to 64 bits.
    function automatic logic [63:0] sat_ceiling(input int unsigned w);
        if (w >= 64)
            return '1;
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/mac_accum_if.sv
// Run control, sample stream and result handshake of the accumulator.
interface mac_accum_if #(
    parameter int BITS     = 8,
    parameter int ACC_BITS = 24,
    parameter int LEN_BITS = 8
) ();
    logic                i_start;
    logic [LEN_BITS-1:0] i_len;
    logic                i_valid;
    logic [BITS-1:0]     i_data;
    logic                o_busy;
    logic                o_valid;
    logic                i_ready;
    logic [ACC_BITS-1:0] o_res;
    logic                o_ovf;

    modport slave (
        input  i_start, i_len, i_valid, i_data, i_ready,
        output o_busy, o_valid, o_res, o_ovf
    );

    modport master (
        output i_start, i_len, i_valid, i_data, i_ready,
        input  o_busy, o_valid, o_res, o_ovf
    );
endinterface

// File: rtl/mac_accum_sat_add.sv
// Combinational unsigned saturating adder; no state, no handshake.
module sat_add
    import mac_accum_pkg::*;
#(
    parameter int ACC_BITS = 24
) (
    input  logic [ACC_BITS-1:0] a_i,
    input  logic [ACC_BITS-1:0] b_i,
    output logic [ACC_BITS-1:0] sum_o,
    output logic                ovf_o
);
    localparam logic [ACC_BITS-1:0] SAT_MAX = ACC_BITS'(sat_ceiling(ACC_BITS));

    logic [ACC_BITS:0] full;

    assign full  = {1'b0, a_i} + {1'b0, b_i};
    assign ovf_o = full[ACC_BITS];
    assign sum_o = ovf_o ? SAT_MAX : full[ACC_BITS-1:0];
endmodule

// File: rtl/mac_accum.sv
// Sums a programmed-length run of unsigned samples with saturation; result valid 1 cycle after
// the last sample and held in HOLD until i_ready; samples are only taken while in ACC.
module mac_accum
    import mac_accum_pkg::*;
#(
    parameter int BITS     = 8,
    parameter int ACC_BITS = 24,
    parameter int LEN_BITS = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    mac_accum_if.slave  bus
);
    state_t              state_q, state_d;
    logic [ACC_BITS-1:0] sum_q, sum_d;
    logic [LEN_BITS-1:0] cnt_q, cnt_d;
    logic [LEN_BITS-1:0] len_q, len_d;
    logic                ovf_q, ovf_d;

    logic [ACC_BITS-1:0] add_sum;
    logic                add_ovf;

    sat_add #(.ACC_BITS(ACC_BITS)) u_sat_add (
        .a_i   (sum_q),
        .b_i   (ACC_BITS'(bus.i_data)),
        .sum_o (add_sum),
        .ovf_o (add_ovf)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            sum_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    sum_d = '0;
                    ovf_d = 1'b0;
                    if (bus.i_len != '0) begin
                        cnt_d   = '0;
                        len_d   = bus.i_len;
                        state_d = ACC;
                    end else begin
                        // Empty run: report a zero result straight away.
                        state_d = HOLD;
                    end
                end
            end
            ACC: begin
                if (bus.i_valid) begin
                    sum_d = add_sum;
                    ovf_d = ovf_q | add_ovf;
                    cnt_d = cnt_q + LEN_BITS'(1);
                    if (cnt_q == len_q - LEN_BITS'(1))
                        state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.i_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.o_busy  = (state_q != IDLE);
    assign bus.o_valid = (state_q == HOLD);
    assign bus.o_res   = sum_q;
    assign bus.o_ovf   = ovf_q;
endmodule

// File: tb/tb_mac_accum.sv
// Directed bench: a 24-bit accumulator driven from a vector table, and a 10-bit one for saturation.
module tb_mac_accum;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mac_accum_if #(.BITS(8), .ACC_BITS(24), .LEN_BITS(8)) ifa ();
    mac_accum_if #(.BITS(8), .ACC_BITS(10), .LEN_BITS(8)) ifb ();

    mac_accum #(.BITS(8), .ACC_BITS(24), .LEN_BITS(8)) dut_a (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (ifa.slave)
    );

    mac_accum #(.BITS(8), .ACC_BITS(10), .LEN_BITS(8)) dut_b (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic [7:0]  len;
        logic        vld;
        logic [7:0]  data;
        logic        rdy;
        logic        e_busy;
        logic        e_valid;
        logic [23:0] e_res;
        logic        e_ovf;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic s, input logic [7:0] l, input logic v, input logic [7:0] d,
                       input logic r, input logic eb, input logic ev, input logic [23:0] er,
                       input logic eo);
        vec_t t;
        t.start = s; t.len = l; t.vld = v; t.data = d; t.rdy = r;
        t.e_busy = eb; t.e_valid = ev; t.e_res = er; t.e_ovf = eo;
        tbl.push_back(t);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic drive_a(input logic s, input logic [7:0] l, input logic v, input logic [7:0] d,
                           input logic r);
        ifa.i_start = s; ifa.i_len = l; ifa.i_valid = v; ifa.i_data = d; ifa.i_ready = r;
    endtask

    task automatic drive_b(input logic s, input logic [7:0] l, input logic v, input logic [7:0] d,
                           input logic r);
        ifb.i_start = s; ifb.i_len = l; ifb.i_valid = v; ifb.i_data = d; ifb.i_ready = r;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_a(input string tag, input logic eb, input logic ev, input logic [23:0] er,
                           input logic eo);
        check({tag, ".busy"},  32'(ifa.o_busy),  32'(eb));
        check({tag, ".valid"}, 32'(ifa.o_valid), 32'(ev));
        check({tag, ".res"},   32'(ifa.o_res),   32'(er));
        check({tag, ".ovf"},   32'(ifa.o_ovf),   32'(eo));
    endtask

    task automatic check_b(input string tag, input logic eb, input logic ev, input logic [9:0] er,
                           input logic eo);
        check({tag, ".busy"},  32'(ifb.o_busy),  32'(eb));
        check({tag, ".valid"}, 32'(ifb.o_valid), 32'(ev));
        check({tag, ".res"},   32'(ifb.o_res),   32'(er));
        check({tag, ".ovf"},   32'(ifb.o_ovf),   32'(eo));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive_a(0, 0, 0, 0, 0);
        drive_b(0, 0, 0, 0, 0);

        // Four samples back-to-back with i_ready high.
        add(1, 4, 0,  0, 1, 1, 0,   0, 0);
        add(0, 0, 1, 10, 1, 1, 0,  10, 0);
        add(0, 0, 1, 20, 1, 1, 0,  30, 0);
        add(0, 0, 1, 30, 1, 1, 0,  60, 0);
        add(0, 0, 1, 40, 1, 1, 1, 100, 0);
        add(0, 0, 0,  0, 1, 0, 0, 100, 0);
        // Gapped samples, result held under backpressure.
        add(1, 3, 0,  0, 0, 1, 0,   0, 0);
        add(0, 0, 1,  5, 0, 1, 0,   5, 0);
        add(0, 0, 0,  0, 0, 1, 0,   5, 0);
        add(0, 0, 0,  0, 0, 1, 0,   5, 0);
        add(0, 0, 1,  7, 0, 1, 0,  12, 0);
        add(0, 0, 0,  0, 0, 1, 0,  12, 0);
        add(0, 0, 0,  0, 0, 1, 0,  12, 0);
        add(0, 0, 1,  9, 0, 1, 1,  21, 0);
        for (int i = 0; i < 4; i++)
            add(0, 0, 0, 0, 0, 1, 1, 21, 0);
        add(0, 0, 0,  0, 1, 0, 0,  21, 0);
        // Zero-length run; stray i_valid/i_start in HOLD and IDLE.
        add(1, 0, 0,  0, 0, 1, 1,   0, 0);
        add(0, 0, 1, 99, 0, 1, 1,   0, 0);
        add(1, 5, 1, 77, 0, 1, 1,   0, 0);
        add(0, 0, 0,  0, 1, 0, 0,   0, 0);
        add(0, 0, 1, 50, 0, 0, 0,   0, 0);
        // i_start during ACC and in the handshake cycle is ignored.
        add(1, 2, 0,  0, 1, 1, 0,   0, 0);
        add(1, 5, 1,  3, 1, 1, 0,   3, 0);
        add(1, 7, 1,  4, 1, 1, 1,   7, 0);
        add(1, 9, 0,  0, 1, 0, 0,   7, 0);
        add(0, 0, 0,  0, 1, 0, 0,   7, 0);

        @(negedge clk);
        @(negedge clk);
        check_a("reset_a", 0, 0, 0, 0);
        check_b("reset_b", 0, 0, 0, 0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) begin
            drive_a(tbl[i].start, tbl[i].len, tbl[i].vld, tbl[i].data, tbl[i].rdy);
            tick();
            check_a($sformatf("vec%0d", i), tbl[i].e_busy, tbl[i].e_valid, tbl[i].e_res,
                    tbl[i].e_ovf);
        end
        drive_a(0, 0, 0, 0, 0);

        // Saturation on the 10-bit accumulator: clamps at 1023 from the 5th sample.
        drive_b(1, 8, 0, 0, 0);
        tick();
        check_b("sat_start", 1, 0, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            drive_b(0, 0, 1, 255, 0);
            tick();
            check_b($sformatf("sat_s%0d", k), 1, (k == 8), (k >= 5) ? 10'd1023 : 10'(255 * k),
                    (k >= 5));
        end
        drive_b(0, 0, 0, 0, 0);
        tick();
        check_b("sat_hold", 1, 1, 1023, 1);
        drive_b(0, 0, 0, 0, 1);
        tick();
        check_b("sat_done", 0, 0, 1023, 1);
        drive_b(1, 1, 0, 0, 0);
        tick();
        check_b("sat_clear", 1, 0, 0, 0);
        drive_b(0, 0, 1, 6, 1);
        tick();
        check_b("sat_next", 1, 1, 6, 0);
        drive_b(0, 0, 0, 0, 1);
        tick();
        drive_b(0, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a run.
        drive_a(1, 4, 0, 0, 1);
        tick();
        drive_a(0, 0, 1, 1, 1);
        tick();
        drive_a(0, 0, 1, 2, 1);
        tick();
        check_a("pre_rst", 1, 0, 3, 0);
        drive_a(0, 0, 0, 0, 1);
        #2 rst_n = 1'b0;
        #1 check_a("async_rst", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive_a(1, 2, 0, 0, 1);
        tick();
        check_a("post_start", 1, 0, 0, 0);
        drive_a(0, 0, 1, 1, 1);
        tick();
        drive_a(0, 0, 1, 2, 1);
        tick();
        check_a("post_res", 1, 1, 3, 0);
        drive_a(0, 0, 0, 0, 1);
        tick();
        check_a("post_idle", 0, 0, 3, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
